// File: rtl/fetch_pkg.sv
// fetch_pkg: state codes, reset instruction word and prefetch-queue entry type
// shared by fetch_unit (FETCH_PERF_EN enables its performance counters).
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_BOOT  = 2'd0;
  localparam fetch_state_t S_RUN   = 2'd1;
  localparam fetch_state_t S_REDIR = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0;

  // The pc field is kept at full word width so any ADDR_W up to 32 fits.
  localparam int PC_W = 32;

  typedef struct packed {
    logic [31:0]     data;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous prefetch queue with push, pop and clear.
// Clear wins over push and pop; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head_entry,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count != '0);

  // Storage is reset so the head reads as a NOP word straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{data: NOP_WORD, pc: '0};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, instruction-flash requests and prefetch queue feeding the IR.
// Define FETCH_PERF_EN to add the fetch_count / flush_count performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_rd_en,
  input  logic [31:0]       dout_flash,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [31:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       flush_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              kill;

  logic [CNT_W-1:0]  q_count;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              issue;
  logic              pop;
  logic              push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic              unused_pc_bits;

  // Words queued plus the one in flight, minus the one leaving this cycle.
  assign pop       = ir_valid && ir_ready;
  assign occupancy = OCC_W'(q_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign credit_ok = occupancy < OCC_W'(DEPTH);
  assign issue     = !rst && !redirect && (state == S_RUN) && credit_ok;

  assign flash_rd_en = issue;
  assign flash_addr  = fetch_pc;

  // Boot and redirect are single-cycle bubbles; everything else settles in S_RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
    end else if (redirect) begin
      state <= S_REDIR;
    end else begin
      state <= S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign push       = inflight && !kill;
  assign push_entry = '{data: dout_flash, pc: PC_W'(inflight_pc)};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head_entry(head_entry),
    .count     (q_count)
  );

  assign ir_valid       = (q_count != '0);
  assign ir_data        = head_entry.data;
  assign ir_pc          = head_entry.pc[ADDR_W-1:0];
  assign unused_pc_bits = ^head_entry.pc;

`ifdef FETCH_PERF_EN
  // A response squashed by a same-cycle redirect never reaches the queue, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && !redirect) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based
// model of the fetch stream; compile with FETCH_PERF_EN to also cover the counters.
module tb_fetch_unit;

  localparam int                ADDR_W   = 10;
  localparam int                DEPTH    = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam int                PC_MOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_rd_en;
  logic [31:0]       dout_flash;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              ir_ready = 1'b0;
  logic              ir_valid;
  logic [31:0]       ir_data;
  logic [ADDR_W-1:0] ir_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count;
  logic [31:0]       flush_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flash_addr (flash_addr),
    .flash_rd_en(flash_rd_en),
    .dout_flash (dout_flash),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ir_ready   (ir_ready),
    .ir_valid   (ir_valid),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  function automatic logic [31:0] flash_word(input int addr);
    return 32'(addr) + 32'd100;
  endfunction

  // Synchronous flash: answers a request one cycle later, garbage otherwise.
  always @(posedge clk) begin
    if (flash_rd_en) dout_flash <= flash_word(int'(flash_addr));
    else             dout_flash <= $urandom();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rd, input int rpc, input bit rdy);
    @(posedge clk);
    #1;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc[ADDR_W-1:0];
    ir_ready    = rdy;
  endtask

  task automatic step(input bit r, input bit rd, input int rpc, input bit rdy);
    applyStimulus(r, rd, rpc, rdy);
    @(negedge clk);
  endtask

  // Reference model: the word stream as a queue of pcs plus the one outstanding request.
  int m_q[$];
  bit m_known = 1'b0;
  bit m_infl  = 1'b0;
  int m_infl_pc = 0;
  int m_pc      = 0;
  int m_wait    = 0;
  int m_fetch   = 0;
  int m_flush   = 0;

  always @(negedge clk) begin
    bit exp_valid;
    bit exp_pop;
    bit exp_rd;
    exp_valid = (m_q.size() != 0);
    exp_pop   = exp_valid && ir_ready;
    exp_rd    = !rst && !redirect && (m_wait == 0) &&
                ((m_q.size() + int'(m_infl) - int'(exp_pop)) < DEPTH);
    if (m_known) begin
      checkOutput("model_ir_valid", 32'(ir_valid), 32'(exp_valid));
      checkOutput("model_flash_rd_en", 32'(flash_rd_en), 32'(exp_rd));
      if (exp_rd) checkOutput("model_flash_addr", 32'(flash_addr), m_pc);
      if (exp_valid) begin
        checkOutput("model_ir_pc", 32'(ir_pc), m_q[0]);
        checkOutput("model_ir_data", ir_data, flash_word(m_q[0]));
      end
`ifdef FETCH_PERF_EN
      checkOutput("model_fetch_count", fetch_count, m_fetch);
      checkOutput("model_flush_count", flush_count, m_flush);
`endif
    end
    if (rst) begin
      m_q.delete();
      m_infl  = 1'b0;
      m_wait  = 1;
      m_pc    = int'(RESET_PC);
      m_fetch = 0;
      m_flush = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_wait = 1;
        m_pc   = int'(redirect_pc);
        m_flush++;
      end else begin
        if (exp_pop) void'(m_q.pop_front());
        if (m_infl) begin
          m_q.push_back(m_infl_pc);
          m_fetch++;
        end
        m_infl    = exp_rd;
        m_infl_pc = m_pc;
        if (exp_rd) m_pc = (m_pc + 1) % PC_MOD;
        if (m_wait > 0) m_wait--;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqs;

    // Reset, then the first words of the stream from address 0.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    step(0, 0, 0, 1);
    checkOutput("reset_rd_en", 32'(flash_rd_en), 32'd0);
    checkOutput("reset_flash_addr", 32'(flash_addr), 32'd0);
    checkOutput("reset_ir_valid", 32'(ir_valid), 32'd0);
    checkOutput("reset_ir_data", ir_data, 32'd0);
    checkOutput("reset_ir_pc", 32'(ir_pc), 32'd0);
    step(0, 0, 0, 1);
    checkOutput("cyc1_rd_en", 32'(flash_rd_en), 32'd1);
    checkOutput("cyc1_addr", 32'(flash_addr), 32'd0);
    step(0, 0, 0, 1);
    checkOutput("cyc2_addr", 32'(flash_addr), 32'd1);
    checkOutput("cyc2_ir_valid", 32'(ir_valid), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      step(0, 0, 0, 1);
      checkOutput("first_words_valid", 32'(ir_valid), 32'd1);
      checkOutput("first_words_data", ir_data, 32'(100 + c - 3));
    end

    // Consumer stalls: the credit rule allows exactly DEPTH requests.
    applyStimulus(1, 0, 0, 0);
    reqs = 0;
    for (int c = 0; c <= 6; c++) begin
      step(0, 0, 0, 0);
      if (flash_rd_en) reqs++;
    end
    checkOutput("stall_request_count", 32'(reqs), 32'(DEPTH));
    checkOutput("stall_rd_en_off", 32'(flash_rd_en), 32'd0);
    for (int c = 7; c <= 9; c++) begin
      step(0, 0, 0, 1);
      checkOutput("release_data", ir_data, 32'(100 + c - 7));
    end
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 1);
      checkOutput("steady_no_bubble", 32'(flash_rd_en), 32'd1);
    end

    // Redirect with a request in flight, then run across the address wrap.
    step(0, 1, 'h3F0, 1);
    checkOutput("redir_blocks_issue", 32'(flash_rd_en), 32'd0);
    step(0, 0, 0, 1);
    checkOutput("redir_t1_valid", 32'(ir_valid), 32'd0);
    step(0, 0, 0, 1);
    checkOutput("redir_t2_rd_en", 32'(flash_rd_en), 32'd1);
    checkOutput("redir_t2_addr", 32'(flash_addr), 32'h3F0);
    step(0, 0, 0, 1);
    checkOutput("redir_t3_valid", 32'(ir_valid), 32'd0);
    step(0, 0, 0, 1);
    checkOutput("redir_t4_valid", 32'(ir_valid), 32'd1);
    checkOutput("redir_t4_pc", 32'(ir_pc), 32'h3F0);
    checkOutput("redir_t4_data", ir_data, 32'h3F0 + 32'd100);
    for (int k = 5; k <= 20; k++) begin
      step(0, 0, 0, 1);
      if (k == 18) begin
        checkOutput("wrap_ir_pc_3fe", 32'(ir_pc), 32'h3FE);
        checkOutput("wrap_flash_addr_0", 32'(flash_addr), 32'h000);
      end
      if (k == 19) checkOutput("wrap_ir_pc_3ff", 32'(ir_pc), 32'h3FF);
      if (k == 20) checkOutput("wrap_ir_pc_000", 32'(ir_pc), 32'h000);
    end

    // Redirect and pop in the same cycle with a full queue.
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0);
    step(0, 1, 'h100, 1);
    checkOutput("redir_pop_head_valid", 32'(ir_valid), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1);
      checkOutput("redir_pop_flushed", 32'(ir_valid), 32'd0);
    end
    step(0, 0, 0, 1);
    checkOutput("redir_pop_new_valid", 32'(ir_valid), 32'd1);
    checkOutput("redir_pop_new_pc", 32'(ir_pc), 32'h100);

    // Mid-run reset clears the queue (and the counters when present).
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    checkOutput("midreset_ir_valid", 32'(ir_valid), 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("midreset_fetch_count", fetch_count, 32'd0);
    checkOutput("midreset_flush_count", flush_count, 32'd0);
    for (int c = 1; c <= 11; c++) step(0, 0, 0, 1);
    step(0, 1, 'h040, 1);
    step(0, 1, 'h080, 1);
    step(0, 0, 0, 1);
    checkOutput("perf_fetch_count_10", fetch_count, 32'd10);
    checkOutput("perf_flush_count_2", flush_count, 32'd2);
`endif

    // Randomized traffic: stalls, redirects (often near the wrap) and rare resets.
    for (int c = 0; c < 3000; c++) begin
      bit r_rst;
      bit r_red;
      int r_pc;
      r_rst = ($urandom_range(0, 999) < 4);
      r_red = !r_rst && ($urandom_range(0, 99) < 4);
      r_pc  = $urandom_range(0, 1) ? int'($urandom_range(0, PC_MOD - 1))
                                   : int'($urandom_range(PC_MOD - 8, PC_MOD - 1));
      step(r_rst, r_red, r_pc, $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
